// File: rtl/neuron_pkg.sv
// Shared definitions for the spiking-population blocks: default population
// size, the count-width helper and the rate-counter FSM state encoding.
package neuron_pkg;

    localparam int N_NEURONS_DEFAULT = 128;

    // Bits needed to hold any count in 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        UPDATE = 2'd2
    } state_e;

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice of the spike vector.
module popcount_chunk
    import neuron_pkg::*;
#(
    parameter int CHUNK = 16,
    parameter int OUT_W = cnt_width(CHUNK)
) (
    input  logic [CHUNK-1:0] bits_i,
    output logic [OUT_W-1:0] count_o
);

    // Ripple sum of the slice bits; CHUNK is small enough for one cycle.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count_o = count_o + OUT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/population_rate_counter.sv
// Per-sweep spike counter with a sliding-window sum over the last
// 2^WIN_LOG2 sweeps. A sweep is latched on pop_valid, popcounted CHUNK bits
// per cycle, then folded into the window ring in a single UPDATE cycle.
// Optional build macro POPULATION_RATE_PEAK_EN adds a running peak register
// behind peak_count; without it peak_count is tied to zero.
module population_rate_counter
    import neuron_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEFAULT,
    parameter int CHUNK     = 16,
    parameter int WIN_LOG2  = 4,
    parameter int CNT_W     = cnt_width(N_NEURONS),
    parameter int SUM_W     = CNT_W + WIN_LOG2
) (
    input  logic                 clk,
    input  logic                 reset_bar,
    input  logic [N_NEURONS-1:0] population,
    input  logic                 pop_valid,
    input  logic                 clear_overrun,
    output logic                 busy,
    output logic [CNT_W-1:0]     sweep_count,
    output logic [SUM_W-1:0]     window_sum,
    output logic                 window_full,
    output logic                 rate_valid,
    output logic                 overrun,
    output logic [CNT_W-1:0]     peak_count
);

    localparam int NCH   = N_NEURONS / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PC_W  = cnt_width(CHUNK);
    localparam int WIN   = 1 << WIN_LOG2;
    localparam int NS_W  = WIN_LOG2 + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
    localparam logic [NS_W-1:0]  NS_FULL  = NS_W'(WIN);

    state_e                 state_q, state_d;
    logic [N_NEURONS-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       sweep_count_q, sweep_count_d;
    logic [SUM_W-1:0]       window_sum_q, window_sum_d;
    logic [WIN_LOG2-1:0]    wp_q, wp_d;
    logic [NS_W-1:0]        nsweep_q, nsweep_d;
    logic                   rate_valid_q, rate_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   ring_we;
    logic [CNT_W-1:0]       ring_q [WIN];

    logic [CHUNK-1:0]       chunk_bits;
    logic [PC_W-1:0]        chunk_pc;

    // Slice of the latched sweep currently being counted.
    assign chunk_bits = shadow_q[int'(idx_q) * CHUNK +: CHUNK];

    popcount_chunk #(
        .CHUNK (CHUNK),
        .OUT_W (PC_W)
    ) u_pc (
        .bits_i  (chunk_bits),
        .count_o (chunk_pc)
    );

    // Next-state and datapath control for the IDLE/COUNT/UPDATE sweep FSM.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        sweep_count_d = sweep_count_q;
        window_sum_d  = window_sum_q;
        wp_d          = wp_q;
        nsweep_d      = nsweep_q;
        rate_valid_d  = 1'b0;
        ring_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop_valid) begin
                    shadow_d = population;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                acc_d = acc_q + CNT_W'(chunk_pc);
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // Modular add/sub is exact: the ring starts zeroed, so the
                // running sum always equals the sum of the ring entries.
                sweep_count_d = acc_q;
                window_sum_d  = window_sum_q + SUM_W'(acc_q) - SUM_W'(ring_q[wp_q]);
                ring_we       = 1'b1;
                wp_d          = wp_q + 1'b1;
                if (nsweep_q != NS_FULL) nsweep_d = nsweep_q + 1'b1;
                rate_valid_d  = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky overrun: a dropped pop_valid beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (pop_valid && (state_q != IDLE)) overrun_d = 1'b1;
        else if (clear_overrun)             overrun_d = 1'b0;
    end

    // Main state and output registers.
    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            acc_q         <= '0;
            idx_q         <= '0;
            sweep_count_q <= '0;
            window_sum_q  <= '0;
            wp_q          <= '0;
            nsweep_q      <= '0;
            rate_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            sweep_count_q <= sweep_count_d;
            window_sum_q  <= window_sum_d;
            wp_q          <= wp_d;
            nsweep_q      <= nsweep_d;
            rate_valid_q  <= rate_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    // Window ring of per-sweep counts; zeroed at reset so eviction is exact.
    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            for (int i = 0; i < WIN; i++) ring_q[i] <= '0;
        end else if (ring_we) begin
            ring_q[wp_q] <= acc_q;
        end
    end

`ifdef POPULATION_RATE_PEAK_EN
    logic [CNT_W-1:0] peak_q;

    // Running maximum of completed sweep counts, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            peak_q <= '0;
        end else if (state_q == UPDATE && acc_q > peak_q) begin
            peak_q <= acc_q;
        end
    end

    assign peak_count = peak_q;
`else
    assign peak_count = '0;
`endif

    assign busy        = (state_q != IDLE);
    assign sweep_count = sweep_count_q;
    assign window_sum  = window_sum_q;
    assign window_full = (nsweep_q == NS_FULL);
    assign rate_valid  = rate_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_population_rate_counter.sv
// Scoreboard bench for population_rate_counter (default parameters).
module tb_population_rate_counter;

    logic         clk = 1'b0;
    logic         reset_bar;
    logic [127:0] population;
    logic         pop_valid;
    logic         clear_overrun;
    logic         busy;
    logic [7:0]   sweep_count;
    logic [11:0]  window_sum;
    logic         window_full;
    logic         rate_valid;
    logic         overrun;
    logic [7:0]   peak_count;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int cnt;
        int sum;
        int full;
        int peak;
    } exp_t;

    exp_t sb[$];
    int   m_ring[16];
    int   m_wp, m_sum, m_n, m_peak;

    population_rate_counter dut (
        .clk           (clk),
        .reset_bar     (reset_bar),
        .population    (population),
        .pop_valid     (pop_valid),
        .clear_overrun (clear_overrun),
        .busy          (busy),
        .sweep_count   (sweep_count),
        .window_sum    (window_sum),
        .window_full   (window_full),
        .rate_valid    (rate_valid),
        .overrun       (overrun),
        .peak_count    (peak_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ring[i] = 0;
        m_wp = 0; m_sum = 0; m_n = 0; m_peak = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_bar = 1'b0; pop_valid = 1'b0; clear_overrun = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_bar = 1'b1;
        model_reset();
    endtask

    // Drives pop_valid for the edge k; returns at k+1ns with the expected
    // result of the sweep queued.
    task automatic send(input logic [127:0] vec);
        exp_t e;
        int c;
        @(posedge clk); #1;
        population = vec;
        pop_valid  = 1'b1;
        c = $countones(vec);
        m_sum = m_sum + c - m_ring[m_wp];
        m_ring[m_wp] = c;
        m_wp = (m_wp + 1) % 16;
        if (m_n < 16) m_n++;
`ifdef POPULATION_RATE_PEAK_EN
        if (c > m_peak) m_peak = c;
`endif
        e.cnt = c; e.sum = m_sum; e.full = (m_n == 16) ? 1 : 0; e.peak = m_peak;
        sb.push_back(e);
        @(posedge clk); #1;
        pop_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until rate_valid (bounded).
    task automatic wait_rv(output int n);
        n = 1;
        @(posedge clk); #1;
        while (!rate_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d want 0", busy); else passes++;
        checks++; if (sweep_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", sweep_count); else passes++;
        checks++; if (window_sum !== 12'd0) $display("FAIL reset_sum: got %0d want 0", window_sum); else passes++;
        checks++; if (window_full !== 1'b0) $display("FAIL reset_full: got %0d want 0", window_full); else passes++;
        checks++; if (rate_valid !== 1'b0) $display("FAIL reset_rv: got %0d want 0", rate_valid); else passes++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %0d want 0", overrun); else passes++;
        checks++; if (peak_count !== 8'd0) $display("FAIL reset_peak: got %0d want 0", peak_count); else passes++;
    endtask

    task automatic test_all_ones();
        int n;
        exp_t e;
        send('1);
        checks++; if (busy !== 1'b1) $display("FAIL ones_busy: got %0d want 1", busy); else passes++;
        wait_rv(n);
        checks++; if (n !== 9) $display("FAIL ones_latency: got %0d want 9", n); else passes++;
        e = sb.pop_front();
        checks++; if (sweep_count !== 8'(e.cnt) || e.cnt != 128) $display("FAIL ones_count: got %0d want 128", sweep_count); else passes++;
        checks++; if (window_sum !== 12'(e.sum) || e.sum != 128) $display("FAIL ones_sum: got %0d want 128", window_sum); else passes++;
        checks++; if (window_full !== 1'b0) $display("FAIL ones_full: got %0d want 0", window_full); else passes++;
        @(posedge clk); #1;
        checks++; if (rate_valid !== 1'b0) $display("FAIL ones_strobe_width: got %0d want 0", rate_valid); else passes++;
        checks++; if (sweep_count !== 8'd128) $display("FAIL ones_hold: got %0d want 128", sweep_count); else passes++;
    endtask

    task automatic test_window_fill();
        int n;
        exp_t e;
        for (int s = 2; s <= 17; s++) begin
            @(posedge clk);
            send((s == 17) ? 128'd0 : '1);
            wait_rv(n);
            e = sb.pop_front();
            checks++;
            if (!rate_valid || sweep_count !== 8'(e.cnt) || window_sum !== 12'(e.sum) || window_full !== 1'(e.full))
                $display("FAIL fill_sweep%0d: got rv=%0d cnt=%0d sum=%0d full=%0d want cnt=%0d sum=%0d full=%0d",
                         s, rate_valid, sweep_count, window_sum, window_full, e.cnt, e.sum, e.full);
            else passes++;
            if (s == 16) begin
                checks++; if (window_sum !== 12'd2048) $display("FAIL fill_sum16: got %0d want 2048", window_sum); else passes++;
                checks++; if (window_full !== 1'b1) $display("FAIL fill_full16: got %0d want 1", window_full); else passes++;
            end
        end
        checks++; if (sweep_count !== 8'd0) $display("FAIL fill_zero_count: got %0d want 0", sweep_count); else passes++;
        checks++; if (window_sum !== 12'd1920) $display("FAIL fill_sum17: got %0d want 1920", window_sum); else passes++;
    endtask

    task automatic test_pattern();
        int n;
        exp_t e;
        logic [127:0] v;
        do_reset();
        send({16{8'hAA}});
        wait_rv(n);
        e = sb.pop_front();
        checks++; if (!rate_valid || sweep_count !== 8'(e.cnt) || e.cnt != 64) $display("FAIL aa_count: got %0d want 64", sweep_count); else passes++;
        v = '0; v[127] = 1'b1;
        send(v);
        wait_rv(n);
        e = sb.pop_front();
        checks++; if (!rate_valid || sweep_count !== 8'(e.cnt) || e.cnt != 1) $display("FAIL msb_count: got %0d want 1", sweep_count); else passes++;
        checks++; if (window_sum !== 12'(e.sum) || e.sum != 65) $display("FAIL msb_sum: got %0d want 65", window_sum); else passes++;
    endtask

    task automatic test_overrun();
        int n, rv;
        exp_t e;
        rv = 0;
        send(128'h0F);
        for (int j = 1; j <= 14; j++) begin
            pop_valid  = (j == 3 || j == 9);
            population = '1;
            @(posedge clk); #1;
            if (rate_valid) begin
                rv++;
                e = sb.pop_front();
                checks++; if (sweep_count !== 8'(e.cnt)) $display("FAIL ovr_count: got %0d want %0d", sweep_count, e.cnt); else passes++;
            end
        end
        pop_valid = 1'b0;
        checks++; if (rv !== 1) $display("FAIL ovr_strobes: got %0d want 1", rv); else passes++;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %0d want 1", overrun); else passes++;
        checks++; if (sweep_count !== 8'd4) $display("FAIL ovr_shadow: got %0d want 4", sweep_count); else passes++;
        // Clear and a fresh overrun on the same edge: overrun must stay set.
        send(128'h0F);
        pop_valid = 1'b1; clear_overrun = 1'b1;
        @(posedge clk); #1;
        pop_valid = 1'b0; clear_overrun = 1'b0;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_clear_race: got %0d want 1", overrun); else passes++;
        wait_rv(n);
        e = sb.pop_front();
        checks++; if (!rate_valid || sweep_count !== 8'(e.cnt)) $display("FAIL ovr_race_count: got %0d want %0d", sweep_count, e.cnt); else passes++;
        @(posedge clk); #1;
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %0d want 0", overrun); else passes++;
    endtask

    task automatic test_reset_mid();
        int n, rv;
        exp_t e;
        rv = 0;
        send('1);
        repeat (3) @(posedge clk);
        #1 reset_bar = 1'b0;
        @(posedge clk); #1;
        reset_bar = 1'b1;
        model_reset();
        for (int j = 0; j < 15; j++) begin
            if (rate_valid) rv++;
            @(posedge clk); #1;
        end
        checks++; if (rv !== 0) $display("FAIL mid_no_strobe: got %0d want 0", rv); else passes++;
        checks++;
        if (busy !== 1'b0 || sweep_count !== 8'd0 || window_sum !== 12'd0 || window_full !== 1'b0 || overrun !== 1'b0 || peak_count !== 8'd0)
            $display("FAIL mid_outputs: got busy=%0d cnt=%0d sum=%0d full=%0d ovr=%0d peak=%0d want all 0",
                     busy, sweep_count, window_sum, window_full, overrun, peak_count);
        else passes++;
        send(128'h0F);
        wait_rv(n);
        e = sb.pop_front();
        checks++; if (!rate_valid || sweep_count !== 8'(e.cnt) || e.cnt != 4) $display("FAIL mid_count: got %0d want 4", sweep_count); else passes++;
        checks++; if (window_sum !== 12'(e.sum) || e.sum != 4) $display("FAIL mid_sum: got %0d want 4", window_sum); else passes++;
    endtask

    task automatic test_peak();
        int n;
        exp_t e;
        logic [127:0] vecs [3];
        vecs[0] = 128'h0F; vecs[1] = '1; vecs[2] = 128'h3FF;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            send(vecs[s]);
            wait_rv(n);
            e = sb.pop_front();
            checks++; if (!rate_valid || peak_count !== 8'(e.peak)) $display("FAIL peak_sweep%0d: got %0d want %0d", s, peak_count, e.peak); else passes++;
        end
`ifdef POPULATION_RATE_PEAK_EN
        checks++; if (peak_count !== 8'd128) $display("FAIL peak_final: got %0d want 128", peak_count); else passes++;
`else
        checks++; if (peak_count !== 8'd0) $display("FAIL peak_final: got %0d want 0", peak_count); else passes++;
`endif
    endtask

    initial begin
        reset_bar = 1'b0;
        population = '0;
        pop_valid = 1'b0;
        clear_overrun = 1'b0;
        model_reset();
        test_reset();
        test_all_ones();
        test_window_fill();
        test_pattern();
        test_overrun();
        test_reset_mid();
        test_peak();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
